wrr_arbiter: RTL and testbench
==============================

Name: wrr_arbiter

Overview:
- Parametrised weighted round-robin arbiter with a registered one-hot grant.
- Successor to the single-cycle round-robin arbiter. Adds per-requester weights: a winner keeps the grant for up to `weight` acknowledged transfers.
- Adds a grant-hold/ack handshake and back-to-back re-arbitration with no idle bubble.
- Sits in front of a shared resource (bus, memory port, output FIFO) serving N masters.

Parameters:
N, 5, number of requesters (N >= 2)
W, 4, width of each per-requester weight field
IDW, $clog2(N), width of grant_id (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N  request per requester, level-sensitive
weight  input  N*W  packed weights, requester i at [i*W +: W]; 0 treated as 1
ack  input  1  granted requester completed one transfer this cycle
grant  output  N  registered one-hot grant, all-zero when idle
grant_valid  output  1  OR of grant, registered
grant_id  output  IDW  binary index of granted requester, 0 when idle

Behaviour:
- Reset (rst_n low, asynchronous):
  - grant=0, grant_valid=0, grant_id=0.
  - Internal pointer=0, credit=0, state=IDLE.
  - Reset takes effect immediately, including mid-burst. After release, the first grant is searched from requester 0.
- State IDLE:
  - If req != 0 at a rising edge, pick the first requester with req set, searching cyclically from `pointer` (pointer, pointer+1, ..., N-1, 0, ...).
  - Register the winner into grant/grant_id, set grant_valid=1, load credit = max(weight[winner], 1), and go to GRANT.
  - Latency: req asserted in cycle t from IDLE gives grant in cycle t+1.
- State GRANT, owner g:
  - ack=1 decrements credit by 1; ack=0 holds it.
  - Release happens at the rising edge when (ack=1 and credit==1) or req[g]==0. A dropped request wins over ack.
  - On release, pointer <= (g+1) mod N.
  - In the same edge, arbitrate among the current req from the new pointer value:
    - If any request is present, grant it directly (stay in GRANT, reload credit). There is no idle cycle between owners.
    - If none, go to IDLE and drive grant=0.
  - Wrap-around: if g is the only requester at release, g is re-granted with fresh credit.
- Weight sampling:
  - weight is sampled only when a grant is loaded.
  - Changes during a burst take effect at the next grant to that requester.
- Ack outside a grant:
  - ack while grant_valid=0 is ignored and does not change pointer or credit.
- Invariants:
  - grant is one-hot or zero at all times.
  - grant_id matches grant.
  - No requester with req=0 is ever granted.
- Fairness: any continuously requesting requester is granted within (N-1) bursts of other owners.
- Arithmetic:
  - credit is W bits.
  - The pointer wrap uses compare-to-N-1, not modulo on non-power-of-2 N.

Test Plan:
- Reset/idle: N=4, W=3, rst_n low with req=4'b1111 -> grant=0, grant_valid=0, grant_id=0. After release, req=4'b0100 -> grant=4'b0100, grant_id=2 one cycle later.
- Weighted burst: req=4'b0011, weight={1,1,3,2}, ack held 1 -> grant sequence 0,0,1,1,1,0,0,... with no gap cycles.
- Request drop: requester 1 granted with weight 5, ack=1 for 2 cycles, then req[1]=0 -> next edge grant moves to next requester (or 0 if none). Pointer=2.
- Wrap-around/single requester: only req[3]=1, weight 2, ack=1 continuously -> grant stays 4'b1000 with credit reloading every 2 acks, and grant_valid never drops.
- Ack stall and weight 0: requester 2 weight 0, ack=0 for 5 cycles then 1 -> grant held all 5 cycles and released after the single ack (weight 0 treated as 1).
- Async reset mid-burst: assert rst_n low between clock edges while grant=4'b0010 -> grant goes 0 immediately without a clock edge. After release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: a winner holds a registered one-hot grant for up to
// max(weight,1) acknowledged transfers, then ownership rotates with no idle bubble.
module wrr_arbiter #(
    parameter  int N   = 5,
    parameter  int W   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] weight,
    input  logic           ack,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state_reg;
    logic [IDW-1:0] pointer_reg;
    logic [W-1:0]   credit_reg;
    logic [N-1:0]   grant_reg;
    logic [IDW-1:0] grant_id_reg;
    logic           grant_valid_reg;

    logic [W-1:0]   w_arr [N];
    logic [IDW-1:0] next_ptr;
    logic [IDW-1:0] search_start;
    logic           release_now;
    logic           win_found;
    logic [IDW-1:0] win_id;
    logic [W-1:0]   win_weight;
    logic [W-1:0]   win_credit;
    logic [N-1:0]   win_onehot;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_weight
            assign w_arr[gi] = weight[gi*W +: W];
        end
    endgenerate

    assign next_ptr     = (grant_id_reg == IDW'(N-1)) ? '0 : grant_id_reg + 1'b1;
    // While a grant is held the search only matters on release, which starts past the owner.
    assign search_start = (state_reg == GRANT) ? next_ptr : pointer_reg;
    assign release_now  = (state_reg == GRANT) &&
                          (!req[grant_id_reg] || (ack && credit_reg == W'(1)));

    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        // Scan farthest-first so the nearest requester from search_start is written last.
        for (int k = N-1; k >= 0; k--) begin
            idx = int'(search_start) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx[IDW-1:0];
            end
        end
    end

    assign win_weight = w_arr[win_id];
    assign win_credit = (win_weight == '0) ? W'(1) : win_weight;
    assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            pointer_reg     <= '0;
            credit_reg      <= '0;
            grant_reg       <= '0;
            grant_id_reg    <= '0;
            grant_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        state_reg       <= GRANT;
                        grant_reg       <= win_onehot;
                        grant_id_reg    <= win_id;
                        grant_valid_reg <= 1'b1;
                        credit_reg      <= win_credit;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        pointer_reg <= next_ptr;
                        if (win_found) begin
                            grant_reg    <= win_onehot;
                            grant_id_reg <= win_id;
                            credit_reg   <= win_credit;
                        end else begin
                            state_reg       <= IDLE;
                            grant_reg       <= '0;
                            grant_id_reg    <= '0;
                            grant_valid_reg <= 1'b0;
                            credit_reg      <= '0;
                        end
                    end else if (ack) begin
                        credit_reg <= credit_reg - 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign grant       = grant_reg;
    assign grant_valid = grant_valid_reg;
    assign grant_id    = grant_id_reg;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed and randomized checks of wrr_arbiter (N=4, W=3) against a transfer-counting model.
module tb_wrr_arbiter;

    localparam int N   = 4;
    localparam int W   = 3;
    localparam int IDW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] weight;
    logic           ack;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;

    int total = 0;
    int bad   = 0;

    // Model: owner and transfers remaining in its burst
    bit m_valid;
    int m_owner;
    int m_left;
    int m_ptr;

    wrr_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .weight(weight), .ack(ack),
        .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_owner = 0;
        m_left  = 0;
        m_ptr   = 0;
    endtask

    task automatic model_pick();
        int i;
        int w;
        m_valid = 1'b0;
        m_owner = 0;
        m_left  = 0;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (req[i]) begin
                w       = int'(weight[i*W +: W]);
                m_valid = 1'b1;
                m_owner = i;
                m_left  = (w == 0) ? 1 : w;
                break;
            end
        end
    endtask

    task automatic model_edge();
        bit rel;
        if (!m_valid) begin
            model_pick();
        end else begin
            rel = 1'b0;
            if (!req[m_owner]) rel = 1'b1;
            else if (ack) begin
                m_left--;
                if (m_left == 0) rel = 1'b1;
            end
            if (rel) begin
                m_ptr = (m_owner + 1) % N;
                model_pick();
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".grant"},       32'(grant),       m_valid ? (32'd1 << m_owner) : 32'd0);
        chk({tag, ".grant_id"},    32'(grant_id),    m_valid ? 32'(m_owner) : 32'd0);
        chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(m_valid));
        $display("%s: req=%b ack=%b grant=%b id=%0d valid=%b", tag, req, ack, grant, grant_id, grant_valid);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [N*W-1:0] pack_w(input int w3, input int w2, input int w1, input int w0);
        return {W'(w3), W'(w2), W'(w1), W'(w0)};
    endfunction

    initial begin
        int exp_seq [7];
        rst_n  = 1'b0;
        req    = 4'b1111;
        weight = pack_w(1, 1, 1, 1);
        ack    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0100;
        step("first_grant");
        chk("first_grant.fixed", 32'(grant), 32'b0100);

        // Weighted burst, ack held high
        apply_reset();
        req    = 4'b0011;
        weight = pack_w(1, 1, 3, 2);
        ack    = 1'b1;
        exp_seq = '{0, 0, 1, 1, 1, 0, 0};
        for (int c = 0; c < 7; c++) begin
            step("burst");
            chk("burst.seq", 32'(grant_id), 32'(exp_seq[c]));
        end

        // Request drop mid-burst
        apply_reset();
        req    = 4'b0010;
        weight = pack_w(1, 1, 5, 1);
        ack    = 1'b1;
        step("drop_grant");
        step("drop_ack1");
        step("drop_ack2");
        req = 4'b1001;
        step("drop_release");
        chk("drop_release.fixed", 32'(grant), 32'b1000);

        // Single requester wraps onto itself
        apply_reset();
        req    = 4'b1000;
        weight = pack_w(2, 1, 1, 1);
        ack    = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step("wrap");
            chk("wrap.valid", 32'(grant_valid), 32'd1);
        end

        // Ack stall with weight 0
        apply_reset();
        req    = 4'b0110;
        weight = pack_w(1, 0, 1, 1);
        ack    = 1'b0;
        step("stall_grant");
        req = 4'b0100;
        step("stall_grant2");
        req = 4'b0110;
        for (int c = 0; c < 5; c++) step("stall_hold");
        chk("stall_hold.fixed", 32'(grant), 32'b0100);
        ack = 1'b1;
        step("stall_release");
        chk("stall_release.fixed", 32'(grant), 32'b0010);

        // Ack while idle is ignored
        apply_reset();
        req = '0;
        ack = 1'b1;
        repeat (3) step("idle_ack");
        req = 4'b0010;
        weight = pack_w(1, 1, 1, 1);
        step("idle_ack_grant");

        // Async reset between edges mid-burst
        apply_reset();
        req    = 4'b0010;
        weight = pack_w(3, 3, 3, 3);
        ack    = 1'b0;
        step("async_pre");
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        chk("async_reset.fixed", 32'(grant), 32'd0);
        #2;
        rst_n = 1'b1;
        req   = 4'b1111;
        step("async_restart");
        chk("async_restart.fixed", 32'(grant_id), 32'd0);

        // Randomized traffic
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3) == 0) req = N'($urandom);
            if ($urandom_range(7) == 0) weight = (N*W)'($urandom);
            ack = 1'($urandom_range(2) != 0);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
